// File: rtl/pixel_seq_pkg.sv
// Shared types and default phase lengths for the pixel array frame sequencer.
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ
  } seq_state_t;

  localparam int unsigned DEF_ROW_WIDTH = 2;
  localparam int unsigned DEF_ADC_BITS  = 8;
  localparam int unsigned DEF_C_ERASE   = 5;
  localparam int unsigned DEF_C_READ    = 5;
  localparam int unsigned DEF_EXP_WIDTH = 16;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_array_sequencer_phase_timer.sv
// Loadable down-counter; tc_next_c flags that the count will be zero next cycle,
// i.e. the following cycle is the last one of the loaded length.
module phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] len_i,
  output logic             tc_next_c
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i - WIDTH'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_next_c = (cnt_d == '0);

endmodule

// File: rtl/pixel_array_sequencer.sv
// Frame sequencer: ERASE -> EXPOSE -> CONVERT (digital ramp) -> READ (row scan),
// with start/busy/done handshake, continuous mode and host abort.
module pixel_array_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int unsigned ROW_WIDTH = DEF_ROW_WIDTH,
  parameter int unsigned ADC_BITS  = DEF_ADC_BITS,
  parameter int unsigned C_ERASE   = DEF_C_ERASE,
  parameter int unsigned C_READ    = DEF_C_READ,
  parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [EXP_WIDTH-1:0] expose_cycles,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic [ADC_BITS-1:0]  ramp_code,
  output logic [ROW_WIDTH-1:0] row_sel,
  output logic                 row_read,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned ROWS     = 2 ** ROW_WIDTH;
  localparam int unsigned CONV_LEN = 2 ** ADC_BITS;
  localparam int unsigned PW       = umax(umax(EXP_WIDTH, ADC_BITS + 1), $clog2(C_ERASE + 1));
  localparam int unsigned DW       = $clog2(C_READ + 1);

  seq_state_t           state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [ADC_BITS-1:0]  ramp_q, ramp_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic                 phase_last_q, dwell_last_q;
  logic                 erase_q, expose_q, convert_q, row_read_q, busy_q, frame_done_q;

  logic                 phase_load, dwell_load, frame_start, frame_done_d;
  logic [PW-1:0]        phase_len;
  logic                 phase_tc_next, dwell_tc_next;

  // Phase length for ERASE / EXPOSE / CONVERT
  phase_timer #(.WIDTH(PW)) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (phase_load),
    .len_i     (phase_len),
    .tc_next_c (phase_tc_next)
  );

  // Per-row dwell during READ
  phase_timer #(.WIDTH(DW)) u_dwell_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (dwell_load),
    .len_i     (DW'(C_READ)),
    .tc_next_c (dwell_tc_next)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    ramp_d      = '0;
    row_d       = '0;
    phase_load  = 1'b0;
    phase_len   = '0;
    dwell_load  = 1'b0;
    frame_start = 1'b0;

    unique case (state_q)
      IDLE: frame_start = start;
      ERASE: begin
        if (phase_last_q) begin
          state_d    = EXPOSE;
          phase_load = 1'b1;
          phase_len  = PW'(exp_q);
        end
      end
      EXPOSE: begin
        if (phase_last_q) begin
          state_d    = CONVERT;
          phase_load = 1'b1;
          phase_len  = PW'(CONV_LEN);
        end
      end
      CONVERT: begin
        if (phase_last_q) begin
          state_d    = READ;
          dwell_load = 1'b1;
        end else begin
          ramp_d = ramp_q + ADC_BITS'(1);
        end
      end
      READ: begin
        row_d = row_q;
        if (dwell_last_q) begin
          if (row_q == ROW_WIDTH'(ROWS - 1)) begin
            row_d = '0;
            if (continuous) begin
              frame_start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            row_d      = row_q + ROW_WIDTH'(1);
            dwell_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New frame: exposure of 0 is stretched to the 1-cycle minimum
    if (frame_start) begin
      state_d    = ERASE;
      phase_load = 1'b1;
      phase_len  = PW'(C_ERASE);
      exp_d      = (expose_cycles == '0) ? EXP_WIDTH'(1) : expose_cycles;
    end

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      exp_d      = exp_q;
      ramp_d     = '0;
      row_d      = '0;
      phase_load = 1'b0;
      dwell_load = 1'b0;
    end

    frame_done_d = (state_d == READ) && (row_d == ROW_WIDTH'(ROWS - 1)) && dwell_tc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      ramp_q       <= '0;
      row_q        <= '0;
      phase_last_q <= 1'b0;
      dwell_last_q <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      row_read_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      ramp_q       <= ramp_d;
      row_q        <= row_d;
      phase_last_q <= phase_tc_next;
      dwell_last_q <= dwell_tc_next;
      erase_q      <= (state_d == ERASE);
      expose_q     <= (state_d == EXPOSE);
      convert_q    <= (state_d == CONVERT);
      row_read_q   <= (state_d == READ);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign ramp_code  = ramp_q;
  assign row_sel    = row_q;
  assign row_read   = row_read_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Self-checking bench: a frame-position model predicts every output each cycle.
module tb_pixel_array_sequencer;

  localparam int RW   = 2;
  localparam int AB   = 4;
  localparam int CE   = 5;
  localparam int CR   = 5;
  localparam int EW   = 16;
  localparam int ROWS = 4;
  localparam int CONV = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, continuous, abort;
  logic [EW-1:0] expose_cycles;
  logic          erase, expose, convert, row_read, busy, frame_done;
  logic [AB-1:0] ramp_code;
  logic [RW-1:0] row_sel;
  logic [11:0]   obs;

  int checks = 0;
  int errors = 0;

  // Model: active flag, cycle index within the frame, latched exposure
  bit m_act = 1'b0;
  int m_t   = 0;
  int m_e   = 1;

  pixel_array_sequencer #(
    .ROW_WIDTH (RW),
    .ADC_BITS  (AB),
    .C_ERASE   (CE),
    .C_READ    (CR),
    .EXP_WIDTH (EW)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .expose_cycles (expose_cycles),
    .erase         (erase),
    .expose        (expose),
    .convert       (convert),
    .ramp_code     (ramp_code),
    .row_sel       (row_sel),
    .row_read      (row_read),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {erase, expose, convert, ramp_code, row_sel, row_read, busy, frame_done};

  function automatic int frame_len();
    return CE + m_e + CONV + ROWS * CR;
  endfunction

  function automatic logic [11:0] model_vec();
    logic er, ex, cv, rd, fd;
    logic [3:0] rc;
    logic [1:0] rs;
    int ro;
    if (!m_act) return 12'h000;
    ro = CE + m_e + CONV;
    er = (m_t < CE);
    ex = (m_t >= CE) && (m_t < CE + m_e);
    cv = (m_t >= CE + m_e) && (m_t < ro);
    rd = (m_t >= ro);
    rc = cv ? 4'(m_t - CE - m_e) : 4'd0;
    rs = rd ? 2'((m_t - ro) / CR) : 2'd0;
    fd = (m_t == frame_len() - 1);
    return {er, ex, cv, rc, rs, rd, 1'b1, fd};
  endfunction

  // Advance one clock and update the model from the inputs sampled at that edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1;
        m_t   = 0;
        m_e   = (expose_cycles == 0) ? 1 : int'(expose_cycles);
      end
    end else if (abort) begin
      m_act = 1'b0;
    end else if (m_t == frame_len() - 1) begin
      if (continuous) begin
        m_t = 0;
        m_e = (expose_cycles == 0) ? 1 : int'(expose_cycles);
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; continuous = 1'b0; abort = 1'b0; expose_cycles = 16'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h want 000", i, obs);
      end
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_single_shot();
    int n_er, n_ex, n_cv, n_done, done_at, max_ramp;
    int rows_hold[ROWS];
    n_er = 0; n_ex = 0; n_cv = 0; n_done = 0; done_at = -1; max_ramp = -1;
    for (int r = 0; r < ROWS; r++) rows_hold[r] = 0;
    expose_cycles = 16'd10; start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      tick();
      start = 1'b0;
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL single_shot cyc %0d: got %h want %h", c, obs, model_vec());
      end
      n_er += int'(erase); n_ex += int'(expose); n_cv += int'(convert);
      if (convert && int'(ramp_code) > max_ramp) max_ramp = int'(ramp_code);
      if (row_read) rows_hold[row_sel]++;
      if (frame_done) begin n_done++; done_at = c; end
    end
    checks++;
    if (n_er !== CE || n_ex !== 10 || n_cv !== CONV || max_ramp !== CONV - 1) begin
      errors++;
      $display("FAIL single_shot_widths: got er=%0d ex=%0d cv=%0d ramp_max=%0d want 5 10 16 15",
               n_er, n_ex, n_cv, max_ramp);
    end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (rows_hold[r] !== CR) begin
        errors++;
        $display("FAIL single_shot_row%0d: got %0d cycles want %0d", r, rows_hold[r], CR);
      end
    end
    checks++;
    if (n_done !== 1 || done_at !== CE + 10 + CONV + ROWS * CR - 1) begin
      errors++;
      $display("FAIL single_shot_done: got count=%0d at=%0d want 1 at %0d",
               n_done, done_at, CE + 10 + CONV + ROWS * CR - 1);
    end
  endtask

  task automatic test_expose_zero();
    int n_ex, new_e;
    new_e = $urandom_range(5, 40);
    for (int f = 0; f < 2; f++) begin
      n_ex = 0;
      if (f == 0) expose_cycles = 16'd0;
      start = 1'b1;
      for (int c = 0; c < 100; c++) begin
        tick();
        start = 1'b0;
        if (f == 0 && c == 3) expose_cycles = 16'(new_e);
        checks++;
        if (obs !== model_vec()) begin
          errors++;
          $display("FAIL expose_zero f%0d cyc %0d: got %h want %h", f, c, obs, model_vec());
        end
        n_ex += int'(expose);
      end
      checks++;
      if (n_ex !== ((f == 0) ? 1 : new_e)) begin
        errors++;
        $display("FAIL expose_width f%0d: got %0d want %0d", f, n_ex, (f == 0) ? 1 : new_e);
      end
    end
  endtask

  task automatic test_continuous();
    int frames;
    bit gap, prev_done;
    frames = 0; gap = 1'b0; prev_done = 1'b0;
    continuous = 1'b1; expose_cycles = 16'($urandom_range(0, 8)); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 600 && m_act; c++) begin
      expose_cycles = 16'($urandom_range(0, 8));
      start = ($urandom_range(0, 5) == 0);
      if (frames == 2 && m_t >= CE + m_e && m_t < CE + m_e + CONV) continuous = 1'b0;
      tick();
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL continuous cyc %0d: got %h want %h", c, obs, model_vec());
      end
      if (prev_done && frames < 3) begin
        checks++;
        if (erase !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL continuous_relaunch: got erase=%b busy=%b want 1 1", erase, busy);
        end
      end
      prev_done = frame_done;
      if (frame_done) frames++;
      if (!busy && frames < 3) gap = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (frames !== 3 || gap || busy !== 1'b0 || m_act) begin
      errors++;
      $display("FAIL continuous_summary: got frames=%0d gap=%0b busy=%b want 3 0 0",
               frames, gap, busy);
    end
  endtask

  task automatic test_abort();
    int c, tgt, n_done;
    n_done = 0;
    continuous = 1'b0;
    for (int f = 0; f < 2; f++) begin
      expose_cycles = 16'($urandom_range(6, 12)); start = 1'b1;
      tick();
      start = 1'b0;
      tgt = (f == 0) ? CE + 4 : CE + m_e + CONV + 2 * CR + $urandom_range(0, CR - 1);
      c = 0;
      while (!(m_act && m_t == tgt) && c < 100) begin
        start = (c == 3);
        tick();
        c++;
        checks++;
        if (obs !== model_vec()) begin
          errors++;
          $display("FAIL abort_run f%0d cyc %0d: got %h want %h", f, c, obs, model_vec());
        end
        if (frame_done) n_done++;
      end
      start = 1'b0;
      checks++;
      if (!(m_act && m_t == tgt)) begin
        errors++;
        $display("FAIL abort_reach f%0d: got t=%0d want %0d (timeout)", f, m_t, tgt);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL abort_idle f%0d: got %h want 000", f, obs);
      end
      for (int i = 0; i < 3; i++) begin
        tick();
        if (frame_done) n_done++;
      end
    end
    checks++;
    if (n_done !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got done=%0d busy=%b want 0 0", n_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int c, tgt;
    expose_cycles = 16'($urandom_range(1, 5)); start = 1'b1;
    tick();
    start = 1'b0;
    tgt = CE + m_e + 7;
    c = 0;
    while (!(m_act && m_t == tgt) && c < 100) begin
      tick();
      c++;
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL reset_mid_run cyc %0d: got %h want %h", c, obs, model_vec());
      end
    end
    checks++;
    if (ramp_code !== 4'd7 || convert !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ramp: got ramp=%0d convert=%b want 7 1", ramp_code, convert);
    end
    rst_n = 1'b0; abort = 1'b1;
    tick();
    rst_n = 1'b1; abort = 1'b0;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h want 000", obs);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL reset_mid_after cyc %0d: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      start         = ($urandom_range(0, 7) == 0);
      abort         = ($urandom_range(0, 79) == 0);
      expose_cycles = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      tick();
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", c, obs, model_vec());
      end
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_expose_zero();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
